// File: rtl/comp_3bit_monitor.sv
// On-chip checker for a magnitude comparator: validates agb/alb/aeb against a golden
// compare, keeps saturating statistics and flags runs of RUN_LEN identical results.
module comp_3bit_monitor #(
    parameter int DATA_W  = 3,
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              agb,
    input  logic              alb,
    input  logic              aeb,
    input  logic              clear,
    output logic [CNT_W-1:0]  gt_cnt,
    output logic [CNT_W-1:0]  lt_cnt,
    output logic [CNT_W-1:0]  eq_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic              run_hit,
    output logic [1:0]        run_kind
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0]       KIND_NONE = 2'b00;
    localparam logic [1:0]       KIND_GT   = 2'b01;
    localparam logic [1:0]       KIND_LT   = 2'b10;
    localparam logic [1:0]       KIND_EQ   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RUN_TGT   = CNT_W'(RUN_LEN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] run_len;
    logic [1:0]       cur_kind;

    logic             accept_p0;
    logic             legal_p0;
    logic             err_p0;
    logic [2:0]       code_p0;
    logic [2:0]       gold_p0;
    logic [1:0]       kind_p0;

    // Stage 0: combinational classification of the offered sample
    assign in_ready  = rst_n & ~clear;
    assign accept_p0 = in_valid & in_ready;
    assign code_p0   = {agb, alb, aeb};
    assign legal_p0  = (code_p0 == 3'b100) || (code_p0 == 3'b010) || (code_p0 == 3'b001);

    always_comb begin
        gold_p0 = 3'b001;
        if (a > b)      gold_p0 = 3'b100;
        else if (a < b) gold_p0 = 3'b010;
    end

    assign err_p0  = !legal_p0 || (code_p0 != gold_p0);
    assign kind_p0 = agb ? KIND_GT : (alb ? KIND_LT : KIND_EQ);

    // Stage 1: counters, sticky error and run tracking update on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_cnt   <= '0;
            lt_cnt   <= '0;
            eq_cnt   <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            run_hit  <= 1'b0;
            run_kind <= KIND_NONE;
            state    <= IDLE;
            run_len  <= '0;
            cur_kind <= KIND_NONE;
        end else if (clear) begin
            gt_cnt   <= '0;
            lt_cnt   <= '0;
            eq_cnt   <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            run_hit  <= 1'b0;
            run_kind <= KIND_NONE;
            state    <= IDLE;
            run_len  <= '0;
            cur_kind <= KIND_NONE;
        end else begin
            run_hit <= 1'b0;
            if (accept_p0) begin
                if (err_p0) begin
                    err_cnt  <= sat_inc(err_cnt);
                    err_flag <= 1'b1;
                    state    <= IDLE;
                    run_len  <= '0;
                end else begin
                    case (kind_p0)
                        KIND_GT: gt_cnt <= sat_inc(gt_cnt);
                        KIND_LT: lt_cnt <= sat_inc(lt_cnt);
                        default: eq_cnt <= sat_inc(eq_cnt);
                    endcase
                    if (state == RUN && kind_p0 == cur_kind) begin
                        // run_len + 1 is compared before it is stored so the hit lands on this edge
                        if (run_len + CNT_ONE == RUN_TGT) begin
                            run_hit  <= 1'b1;
                            run_kind <= cur_kind;
                            state    <= IDLE;
                            run_len  <= '0;
                        end else begin
                            run_len <= run_len + CNT_ONE;
                        end
                    end else begin
                        state    <= RUN;
                        run_len  <= CNT_ONE;
                        cur_kind <= kind_p0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_3bit_monitor.sv
// Randomized and directed bench for comp_3bit_monitor against a queue-based reference model.
module tb_comp_3bit_monitor;

    localparam int DATA_W  = 3;
    localparam int CNT_W   = 8;
    localparam int RUN_LEN = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] a = '0;
    logic [DATA_W-1:0] b = '0;
    logic              agb = 1'b0;
    logic              alb = 1'b0;
    logic              aeb = 1'b0;
    logic              clear = 1'b0;
    logic [CNT_W-1:0]  gt_cnt;
    logic [CNT_W-1:0]  lt_cnt;
    logic [CNT_W-1:0]  eq_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_flag;
    logic              run_hit;
    logic [1:0]        run_kind;

    comp_3bit_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .agb(agb), .alb(alb), .aeb(aeb), .clear(clear),
        .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .run_hit(run_hit), .run_kind(run_kind)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         m_gt, m_lt, m_eq, m_err;
    bit         m_flag, m_hit;
    logic [1:0] m_kind;
    logic [1:0] streak[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
        m_flag = 0; m_hit = 0; m_kind = 2'b00;
        streak.delete();
    endtask

    function automatic int sat(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_accept(input int ua, input int ub, input logic [2:0] code);
        logic [2:0] gold;
        logic [1:0] k;
        m_hit = 0;
        gold = (ua > ub) ? 3'b100 : (ua < ub) ? 3'b010 : 3'b001;
        if ($countones(code) != 1 || code != gold) begin
            m_err  = sat(m_err);
            m_flag = 1;
            streak.delete();
        end else begin
            if (ua > ub)      begin k = 2'b01; m_gt = sat(m_gt); end
            else if (ua < ub) begin k = 2'b10; m_lt = sat(m_lt); end
            else              begin k = 2'b11; m_eq = sat(m_eq); end
            if (streak.size() > 0 && streak[$] != k) streak.delete();
            streak.push_back(k);
            if (streak.size() == RUN_LEN) begin
                m_hit  = 1;
                m_kind = k;
                streak.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check("gt_cnt",   32'(gt_cnt),   32'(m_gt));
        check("lt_cnt",   32'(lt_cnt),   32'(m_lt));
        check("eq_cnt",   32'(eq_cnt),   32'(m_eq));
        check("err_cnt",  32'(err_cnt),  32'(m_err));
        check("err_flag", 32'(err_flag), 32'(m_flag));
        check("run_hit",  32'(run_hit),  32'(m_hit));
        check("run_kind", 32'(run_kind), 32'(m_kind));
    endtask

    task automatic step(input bit v, input int ua, input int ub, input logic [2:0] code, input bit clr);
        @(negedge clk);
        in_valid = v; a = DATA_W'(ua); b = DATA_W'(ub); {agb, alb, aeb} = code; clear = clr;
        #1;
        check("in_ready", 32'(in_ready), 32'(!clr));
        @(posedge clk);
        if (clr) model_reset();
        else if (v) model_accept(ua, ub, code);
        else m_hit = 0;
        #1;
        check_outputs();
    endtask

    function automatic logic [2:0] golden(input int ua, input int ub);
        return (ua > ub) ? 3'b100 : (ua < ub) ? 3'b010 : 3'b001;
    endfunction

    initial begin
        model_reset();
        #12;
        check_outputs();
        check("in_ready_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 5, 3, 3'b100, 0);
        for (int i = 0; i < 4; i++) step(1, 2, 2, 3'b001, 0);
        check("hit_eq_kind", 32'(run_kind), 32'd3);
        step(1, 4, 4, 3'b101, 0);
        check("bad101_flag", 32'(err_flag), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 5, 3, 3'b100, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 6, 3'b010, 0);
        check("hit_lt_kind", 32'(run_kind), 32'd2);
        step(0, 1, 6, 3'b010, 0);
        for (int i = 0; i < 300; i++) step(1, 5, 3, 3'b100, 0);
        check("gt_sat", 32'(gt_cnt), 32'd255);
        step(1, 5, 3, 3'b100, 1);
        step(0, 0, 0, 3'b000, 0);

        for (int i = 0; i < 3; i++) step(1, 6, 6, 3'b001, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("in_ready_async", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 6, 6, 3'b001, 0);

        for (int i = 0; i < 600; i++) begin
            int ra, rb;
            logic [2:0] code;
            bit v, clr;
            ra = int'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 7));
            code = ($urandom_range(0, 7) < 6) ? golden(ra, rb) : 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 9) < 9);
            clr = ($urandom_range(0, 59) == 0);
            step(v, ra, rb, code, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
